sgmii_tx_feeder: RTL and testbench
==================================

Name: sgmii_tx_feeder

Overview:
- Upstream neighbour of the SGMII transmit converter.
- Accepts the pipeline's 134-bit packet stream, polices framing and length, and writes words into the transmitter's data FIFO.
- Writes exactly one validity flag per packet into the transmitter's valid FIFO, so bad packets are discarded downstream rather than sent.
- Repairs broken framing so the downstream FIFO always holds complete head..tail packets.

Parameters:
- MIN_BYTES, 60: smallest length flagged valid (CRC excluded).
- MAX_BYTES, 1518: largest length flagged valid.
- LEN_W, 16: width of the byte counter; the counter saturates at all-ones.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  single clock; also the write clock of the downstream FIFOs.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_data  in  134  [133:132] 01=head, 11=middle, 10=tail; [131:130] tail unused-word code; [129:128] tail unused-byte mod; [127:0] payload, MSB-first.
- in_ready  out  1  word accepted when in_valid&&in_ready.
- data_in_wrreq  out  1  write to transmitter data FIFO.
- data_in  out  134  word written.
- data_in_almostfull  in  1  transmitter data FIFO almost full.
- data_in_valid_wrreq  out  1  write to transmitter valid FIFO.
- data_in_valid  out  1  1 = send packet, 0 = discard.
- orphan_drop  out  1  one-cycle pulse when a middle/tail word arrives outside a packet.
- good_pkts  out  CNT_W  statistic (optional feature).
- bad_pkts  out  CNT_W  statistic (optional feature).

Behaviour:
- Reset: all outputs 0; state IDLE; byte count 0; hold register 0.
- in_ready = !data_in_almostfull && state!=FIX. Combinational.
- All FIFO-side outputs are registered, giving 1 cycle latency from the accept edge.
- Bytes in a tail word = 4*(4-[131:130]) - [129:128].
  - Example: code 11, mod 00 is 4 bytes; code 00, mod 01 is 15 bytes.
  - Head and middle words count 16 bytes.
  - A head that is also tail does not exist; a head is always followed by a tail.
- IDLE:
  - Accepted head: forward it, len=16, error=0, go to IN_PKT.
  - Accepted middle/tail: not forwarded; pulse orphan_drop; stay in IDLE.
- IN_PKT:
  - Accepted middle: forward it; len+=16, saturating.
  - Accepted tail: forward it and write the valid flag in the same cycle.
    - data_in_valid = !error && MIN_BYTES<=final_len<=MAX_BYTES.
    - Go to IDLE.
  - Accepted head: write a synthetic tail (payload 0, [133:128]=10_00_00) plus valid flag 0 in the same cycle; capture the head in the hold register; go to FIX.
- FIX: in_ready is 0. Write the held head, len=16, error=0, go to IN_PKT.
- Oversize is not truncated: words keep forwarding and the flag is 0 at tail. The downstream discard path consumes them.
- At most one data write and one valid write per cycle.
- data_in_almostfull rising mid-packet stalls input only; no word is lost or duplicated.
- Reset mid-packet returns to IDLE immediately. Any partial packet already in the downstream FIFOs is cleared by the shared reset.

Optional Feature:
- SGMII_TX_FEEDER_STATS_EN defined:
  - good_pkts increments on each flag=1 write; bad_pkts increments on each flag=0 write, including synthetic tails.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Not defined: good_pkts and bad_pkts are tied to 0 and no counter logic is built.

Test Plan:
- Head, 2 middles, tail code 00 mod 00 (64 B), in_valid held 1 -> 4 data writes, 1-cycle latency; valid flag 1 with the tail; good_pkts=1.
- Head + tail code 11 mod 00 (20 B) -> 2 writes; flag 0 (runt); bad_pkts=1.
- 96 full words with tail code 00 (1536 B) -> all 96 words forwarded; flag 0 with the tail.
- Head, middle, then a new head, middle, tail (64 B) -> in the order:
  - writes head, middle;
  - synthetic tail 0x2000…0 with flag 0;
  - in_ready=0 for 1 cycle, then the held head;
  - middle, tail with flag 1.
- Tail word while IDLE -> no FIFO write; orphan_drop pulses 1 cycle.
- data_in_almostfull=1 for 5 cycles mid-packet, then reset asserted mid-packet ->
  - in_ready=0 and no writes during the stall; after release, the remaining words are forwarded in order;
  - on reset, outputs are 0 the same cycle and state is IDLE.

Source files
------------

// File: rtl/sgmii_tx_feeder.sv
// Polices the 134-bit packet stream in front of the SGMII transmitter and writes its data and valid FIFOs.
// Define SGMII_TX_FEEDER_STATS_EN to build the good_pkts/bad_pkts counters; otherwise they read 0.
module sgmii_tx_feeder #(
  parameter int MIN_BYTES = 60,
  parameter int MAX_BYTES = 1518,
  parameter int LEN_W     = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [133:0]     in_data,
  output logic             in_ready,
  output logic             data_in_wrreq,
  output logic [133:0]     data_in,
  input  logic             data_in_almostfull,
  output logic             data_in_valid_wrreq,
  output logic             data_in_valid,
  output logic             orphan_drop,
  output logic [CNT_W-1:0] good_pkts,
  output logic [CNT_W-1:0] bad_pkts
);

  typedef enum logic [1:0] {IDLE, IN_PKT, FIX} state_t;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [133:0] SYNTH_TAIL = {2'b10, 4'b0000, 128'd0};

  state_t           state, state_n;
  logic [LEN_W-1:0] len, len_n;
  logic             error, error_n;
  logic [133:0]     hold, hold_n;
  logic             wr_n, vwr_n, vflag_n, orphan_n;
  logic [133:0]     data_n;

  logic             accept;
  logic [4:0]       tail_bytes;
  logic [LEN_W:0]   mid_sum, tail_sum;
  logic [LEN_W-1:0] mid_len, tail_len;
  logic             tail_ok;

  assign in_ready = !reset && !data_in_almostfull && (state != FIX);
  assign accept   = in_valid && in_ready;

  // Tail byte count is 4 per used 32-bit word minus the unused bytes of the last word.
  assign tail_bytes = {3'd4 - {1'b0, in_data[131:130]}, 2'b00} - {3'b000, in_data[129:128]};
  assign mid_sum    = {1'b0, len} + (LEN_W+1)'(16);
  assign tail_sum   = {1'b0, len} + (LEN_W+1)'(tail_bytes);
  assign mid_len    = mid_sum[LEN_W]  ? '1 : mid_sum[LEN_W-1:0];
  assign tail_len   = tail_sum[LEN_W] ? '1 : tail_sum[LEN_W-1:0];
  assign tail_ok    = !error && !tail_sum[LEN_W] &&
                      (tail_len >= LEN_W'(MIN_BYTES)) && (tail_len <= LEN_W'(MAX_BYTES));

  always_comb begin
    state_n  = state;
    len_n    = len;
    error_n  = error;
    hold_n   = hold;
    data_n   = data_in;
    wr_n     = 1'b0;
    vwr_n    = 1'b0;
    vflag_n  = data_in_valid;
    orphan_n = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_data[133:132] == HEAD) begin
            wr_n    = 1'b1;
            data_n  = in_data;
            len_n   = LEN_W'(16);
            error_n = 1'b0;
            state_n = IN_PKT;
          end else if (in_data[133:132] == MID || in_data[133:132] == TAIL) begin
            orphan_n = 1'b1;
          end
        end
      end
      IN_PKT: begin
        if (accept) begin
          case (in_data[133:132])
            MID: begin
              wr_n    = 1'b1;
              data_n  = in_data;
              len_n   = mid_len;
              error_n = error || mid_sum[LEN_W];
            end
            TAIL: begin
              wr_n    = 1'b1;
              data_n  = in_data;
              len_n   = tail_len;
              vwr_n   = 1'b1;
              vflag_n = tail_ok;
              state_n = IDLE;
            end
            // A head inside a packet closes the open one with a discarded synthetic tail.
            HEAD: begin
              wr_n    = 1'b1;
              data_n  = SYNTH_TAIL;
              vwr_n   = 1'b1;
              vflag_n = 1'b0;
              hold_n  = in_data;
              state_n = FIX;
            end
            default: ;
          endcase
        end
      end
      FIX: begin
        wr_n    = 1'b1;
        data_n  = hold;
        len_n   = LEN_W'(16);
        error_n = 1'b0;
        state_n = IN_PKT;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      len                 <= '0;
      error               <= 1'b0;
      hold                <= '0;
      data_in_wrreq       <= 1'b0;
      data_in             <= '0;
      data_in_valid_wrreq <= 1'b0;
      data_in_valid       <= 1'b0;
      orphan_drop         <= 1'b0;
    end else begin
      state               <= state_n;
      len                 <= len_n;
      error               <= error_n;
      hold                <= hold_n;
      data_in_wrreq       <= wr_n;
      data_in             <= data_n;
      data_in_valid_wrreq <= vwr_n;
      data_in_valid       <= vflag_n;
      orphan_drop         <= orphan_n;
    end
  end

`ifdef SGMII_TX_FEEDER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_pkts <= '0;
      bad_pkts  <= '0;
    end else if (vwr_n) begin
      if (vflag_n) good_pkts <= good_pkts + CNT_W'(1);
      else         bad_pkts  <= bad_pkts + CNT_W'(1);
    end
  end
`else
  assign good_pkts = '0;
  assign bad_pkts  = '0;
`endif

endmodule

// File: tb/tb_sgmii_tx_feeder.sv
// Directed and randomized bench for sgmii_tx_feeder, checked against a packet-level reference model.
module tb_sgmii_tx_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [133:0] in_data;
  logic         in_ready;
  logic         data_in_wrreq;
  logic [133:0] data_in;
  logic         data_in_almostfull;
  logic         data_in_valid_wrreq;
  logic         data_in_valid;
  logic         orphan_drop;
  logic [31:0]  good_pkts;
  logic [31:0]  bad_pkts;

  always #5 clk = ~clk;

  sgmii_tx_feeder dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .data_in_wrreq       (data_in_wrreq),
    .data_in             (data_in),
    .data_in_almostfull  (data_in_almostfull),
    .data_in_valid_wrreq (data_in_valid_wrreq),
    .data_in_valid       (data_in_valid),
    .orphan_drop         (orphan_drop),
    .good_pkts           (good_pkts),
    .bad_pkts            (bad_pkts)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: packet open flag, running byte count, and a pending re-issued head.
  bit           m_in_pkt, m_pending, rand_af;
  int           m_bytes, m_good, m_bad;
  logic [133:0] m_held;
  logic         e_wr, e_vwr, e_vflag, e_orphan;
  logic [133:0] e_data;

  localparam logic [133:0] SYNTH = {2'b10, 4'b0000, 128'd0};

  function automatic logic [127:0] rand_payload();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_output(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_pkt  = 0;
    m_pending = 0;
    m_bytes   = 0;
    m_good    = 0;
    m_bad     = 0;
  endtask

  task automatic model_step(input bit acc, input logic [133:0] w);
    e_wr = 0; e_vwr = 0; e_vflag = 0; e_orphan = 0; e_data = '0;
    if (m_pending) begin
      e_wr = 1; e_data = m_held;
      m_pending = 0; m_in_pkt = 1; m_bytes = 16;
    end else if (acc) begin
      case (w[133:132])
        2'b01: begin
          e_wr = 1;
          if (!m_in_pkt) begin
            e_data = w; m_in_pkt = 1; m_bytes = 16;
          end else begin
            e_data = SYNTH; e_vwr = 1; e_vflag = 0;
            m_pending = 1; m_held = w;
          end
        end
        2'b11: begin
          if (m_in_pkt) begin e_wr = 1; e_data = w; m_bytes += 16; end
          else e_orphan = 1;
        end
        2'b10: begin
          if (m_in_pkt) begin
            e_wr = 1; e_data = w; e_vwr = 1;
            m_bytes += 4 * (4 - int'(w[131:130])) - int'(w[129:128]);
            e_vflag = (m_bytes >= 60) && (m_bytes <= 1518);
            m_in_pkt = 0;
          end else e_orphan = 1;
        end
        default: ;
      endcase
    end
    if (e_vwr) begin
      if (e_vflag) m_good++;
      else m_bad++;
    end
  endtask

  task automatic check_stats();
`ifdef SGMII_TX_FEEDER_STATS_EN
    check_output("good_pkts", good_pkts, m_good);
    check_output("bad_pkts", bad_pkts, m_bad);
`else
    check_output("good_pkts", good_pkts, 0);
    check_output("bad_pkts", bad_pkts, 0);
`endif
  endtask

  // One clock cycle: check the combinational ready, then the registered outputs after the edge.
  task automatic apply_stimulus(output bit acc);
    logic exp_ready;
    if (rand_af) data_in_almostfull = ($urandom_range(0, 3) == 0);
    #2;
    exp_ready = !data_in_almostfull && !m_pending;
    check_output("in_ready", in_ready, exp_ready);
    acc = in_valid && exp_ready;
    model_step(acc, in_data);
    @(posedge clk);
    #1;
    check_output("data_wrreq", data_in_wrreq, e_wr);
    check_output("valid_wrreq", data_in_valid_wrreq, e_vwr);
    check_output("orphan_drop", orphan_drop, e_orphan);
    if (e_wr)  check_output("data_in", data_in, e_data);
    if (e_vwr) check_output("valid_flag", data_in_valid, e_vflag);
    check_stats();
  endtask

  task automatic send_word(input logic [1:0] typ, input logic [1:0] code, input logic [1:0] md);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = {typ, code, md, rand_payload()};
    do begin
      apply_stimulus(acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      failures++;
      $error("[TB] FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) apply_stimulus(acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_wrreq"}, data_in_wrreq, 0);
    check_output({tag, "_data"}, data_in, 0);
    check_output({tag, "_vwrreq"}, data_in_valid_wrreq, 0);
    check_output({tag, "_vflag"}, data_in_valid, 0);
    check_output({tag, "_orphan"}, orphan_drop, 0);
    check_output({tag, "_ready"}, in_ready, 0);
    check_output({tag, "_good"}, good_pkts, 0);
    check_output({tag, "_bad"}, bad_pkts, 0);
  endtask

  initial begin
    bit acc;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    data_in_almostfull = 1'b0;
    rand_af = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 64-byte good packet with in_valid held high.
    send_word(2'b01, 2'b00, 2'b00);
    send_word(2'b11, 2'b00, 2'b00);
    send_word(2'b11, 2'b00, 2'b00);
    send_word(2'b10, 2'b00, 2'b00);
    idle(2);

    // 20-byte runt.
    send_word(2'b01, 2'b00, 2'b00);
    send_word(2'b10, 2'b11, 2'b00);
    idle(1);

    // 1536-byte oversize packet.
    send_word(2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 94; i++) send_word(2'b11, 2'b00, 2'b00);
    send_word(2'b10, 2'b00, 2'b00);
    idle(1);

    // Head arriving mid-packet is repaired with a synthetic tail.
    send_word(2'b01, 2'b00, 2'b00);
    send_word(2'b11, 2'b00, 2'b00);
    send_word(2'b01, 2'b00, 2'b00);
    send_word(2'b11, 2'b00, 2'b00);
    send_word(2'b10, 2'b00, 2'b00);
    idle(1);

    // Orphans while idle.
    send_word(2'b10, 2'b01, 2'b10);
    send_word(2'b11, 2'b00, 2'b00);
    idle(2);

    // Boundary lengths: exactly 60 and exactly 1518 bytes.
    send_word(2'b01, 2'b00, 2'b00);
    send_word(2'b11, 2'b00, 2'b00);
    send_word(2'b11, 2'b00, 2'b00);
    send_word(2'b10, 2'b01, 2'b00);
    send_word(2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 93; i++) send_word(2'b11, 2'b00, 2'b00);
    send_word(2'b10, 2'b00, 2'b10);
    idle(1);

    // Almost-full stall mid-packet, then resume.
    send_word(2'b01, 2'b00, 2'b00);
    send_word(2'b11, 2'b00, 2'b00);
    data_in_almostfull = 1'b1;
    in_valid = 1'b1;
    in_data = {2'b11, 4'b0000, rand_payload()};
    for (int i = 0; i < 5; i++) apply_stimulus(acc);
    data_in_almostfull = 1'b0;
    send_word(2'b11, 2'b00, 2'b00);
    send_word(2'b10, 2'b00, 2'b00);

    // Reset in the middle of a packet clears outputs immediately.
    send_word(2'b01, 2'b00, 2'b00);
    send_word(2'b11, 2'b00, 2'b00);
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_word(2'b11, 2'b00, 2'b00);
    idle(1);

    // Randomized packets with random back-pressure and broken framing.
    rand_af = 1;
    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 4) == 0) send_word(2'b10, 2'($urandom), 2'($urandom));
      send_word(2'b01, 2'b00, 2'b00);
      for (int k = $urandom_range(0, 6); k > 0; k--) send_word(2'b11, 2'b00, 2'b00);
      if ($urandom_range(0, 5) != 0) send_word(2'b10, 2'($urandom), 2'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    send_word(2'b10, 2'b00, 2'b00);
    rand_af = 0;
    data_in_almostfull = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
